// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scheduler.
// Contents: register/pc widths, error bit indices, control FSM state type.
package hazard_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned ERR_W     = 2;
    localparam int unsigned ERR_PROTO = 0;
    localparam int unsigned ERR_TMO   = 1;
    localparam int unsigned PERF_W    = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/writeback request bus and hazard/redirect response bus.
// master: pipeline side (drives dec_*/wb_*, receives hazard, redirect, busy, err).
// slave : hazard_ctrl side.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic             dec_valid;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic [REG_W-1:0] dec_rd;
    logic             dec_rd_we;
    logic             dec_is_branch;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             wb_rd_we;
    logic             wb_br_valid;
    logic [PC_W-1:0]  wb_br_target;
    logic             is_data_hazard;
    logic [PC_W-1:0]  irreg_pc;
    logic             br_busy;
    logic [ERR_W-1:0] err;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_is_branch,
        output wb_valid, wb_rd, wb_rd_we, wb_br_valid, wb_br_target,
        input  is_data_hazard, irreg_pc, br_busy, err
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_is_branch,
        input  wb_valid, wb_rd, wb_rd_we, wb_br_valid, wb_br_target,
        output is_data_hazard, irreg_pc, br_busy, err
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters with RAW/overflow lookup.
// Ports: clk, rstd (async active-low); inc_en/inc_rd (issue), dec_en/dec_rd (retire);
//        look_* (decode operands); hazard_c (comb stall), proto_err_c (comb saturation event).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             inc_en,
    input  logic [REG_W-1:0] inc_rd,
    input  logic             dec_en,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             look_valid,
    input  logic [REG_W-1:0] look_rs1,
    input  logic [REG_W-1:0] look_rs2,
    input  logic [REG_W-1:0] look_rd,
    input  logic             look_rd_we,
    output logic             hazard_c,
    output logic             proto_err_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pend_q [NREG];
    logic [CNT_W-1:0] pend_d [NREG];
    logic             inc_live, dec_live, same_reg;
    logic             hz_rs1, hz_rs2, hz_rd;

    // Counter update; x0 is never tracked, issue+retire on one reg cancels.
    always_comb begin
        pend_d      = pend_q;
        proto_err_c = 1'b0;
        inc_live    = inc_en && (inc_rd != '0);
        dec_live    = dec_en && (dec_rd != '0);
        same_reg    = inc_live && dec_live && (inc_rd == dec_rd);
        if (!same_reg) begin
            if (inc_live) begin
                if (pend_q[inc_rd] == CNT_MAX) proto_err_c = 1'b1;
                else pend_d[inc_rd] = pend_q[inc_rd] + CNT_W'(1);
            end
            if (dec_live) begin
                if (pend_q[dec_rd] == '0) proto_err_c = 1'b1;
                else pend_d[dec_rd] = pend_q[dec_rd] - CNT_W'(1);
            end
        end
    end

    // Lookup uses registered counts only: no writeback bypass.
    always_comb begin
        hz_rs1   = (look_rs1 != '0) && (pend_q[look_rs1] != '0);
        hz_rs2   = (look_rs2 != '0) && (pend_q[look_rs2] != '0);
        hz_rd    = look_rd_we && (look_rd != '0) && (pend_q[look_rd] == CNT_MAX);
        hazard_c = look_valid && (hz_rs1 || hz_rs2 || hz_rd);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            for (int i = 0; i < int'(NREG); i++) pend_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) pend_q[i] <= pend_d[i];
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: RAW stall via scoreboard, branch stall/redirect sequencing.
// Ports: clk, rstd (async active-low), bus (hazard_ctrl_if.slave).
// Optional HAZARD_PERF_CNT_EN: adds perf_data_stall / perf_br_stall cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned BR_TMO = 64
) (
    input  logic         clk,
    input  logic         rstd,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_data_stall,
    output logic [PERF_W-1:0] perf_br_stall
`endif
);

    localparam int unsigned TMR_W = $clog2(BR_TMO + 1);

    ctrl_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PC_W-1:0]  irreg_pc_q, irreg_pc_d;
    logic             br_busy_q, br_busy_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             hazard_c, sb_proto_c, issue_c;

    assign issue_c = bus.dec_valid && !hazard_c && (state_q == RUN);

    hazard_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk         (clk),
        .rstd        (rstd),
        .inc_en      (issue_c && bus.dec_rd_we),
        .inc_rd      (bus.dec_rd),
        .dec_en      (bus.wb_valid && bus.wb_rd_we),
        .dec_rd      (bus.wb_rd),
        .look_valid  (bus.dec_valid),
        .look_rs1    (bus.dec_rs1),
        .look_rs2    (bus.dec_rs2),
        .look_rd     (bus.dec_rd),
        .look_rd_we  (bus.dec_rd_we),
        .hazard_c    (hazard_c),
        .proto_err_c (sb_proto_c)
    );

    // Branch sequencing, timeout timer, redirect capture and sticky errors.
    always_comb begin
        state_d    = state_q;
        tmr_d      = '0;
        irreg_pc_d = '0;
        err_d      = err_q;
        case (state_q)
            RUN: begin
                if (issue_c && bus.dec_is_branch) state_d = BR_WAIT;
            end
            BR_WAIT: begin
                tmr_d = (tmr_q == TMR_W'(BR_TMO)) ? tmr_q : tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(BR_TMO - 1)) err_d[ERR_TMO] = 1'b1;
                if (bus.wb_br_valid) begin
                    state_d    = REDIRECT;
                    irreg_pc_d = bus.wb_br_target;
                    // Target 0 collides with the "no redirect" encoding.
                    if (bus.wb_br_target == '0) err_d[ERR_PROTO] = 1'b1;
                end
            end
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (bus.wb_br_valid && (state_q != BR_WAIT)) err_d[ERR_PROTO] = 1'b1;
        if (bus.dec_valid && bus.dec_is_branch && (state_q != RUN)) err_d[ERR_PROTO] = 1'b1;
        if (sb_proto_c) err_d[ERR_PROTO] = 1'b1;
        br_busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q    <= RUN;
            tmr_q      <= '0;
            irreg_pc_q <= '0;
            br_busy_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            irreg_pc_q <= irreg_pc_d;
            br_busy_q  <= br_busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.is_data_hazard = hazard_c;
    assign bus.irreg_pc       = irreg_pc_q;
    assign bus.br_busy        = br_busy_q;
    assign bus.err            = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_data_q, perf_data_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;

    // Stall cycle counters; wrap naturally at 2**32.
    always_comb begin
        perf_data_d = perf_data_q + PERF_W'(hazard_c);
        perf_br_d   = perf_br_q + PERF_W'(br_busy_q);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            perf_data_q <= '0;
            perf_br_q   <= '0;
        end else begin
            perf_data_q <= perf_data_d;
            perf_br_q   <= perf_br_d;
        end
    end

    assign perf_data_stall = perf_data_q;
    assign perf_br_stall   = perf_br_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expectations from a behavioural model are
// queued by the driver and popped/compared by an independent monitor on the falling edge.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int NREG     = 32;
    localparam int CNT_W    = 2;
    localparam int BR_TMO   = 64;
    localparam int PEND_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        dv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        wv;
        logic [4:0]  wrd;
        logic        wwe;
        logic        wbr;
        logic [31:0] tgt;
    } stim_t;

    typedef struct packed {
        logic        hz;
        logic        busy;
        logic [31:0] pc;
        logic [1:0]  err;
        logic [31:0] pd;
        logic [31:0] pb;
    } exp_t;

    logic clk = 1'b0;
    logic rstd;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_data_stall, perf_br_stall;
`endif

    hazard_ctrl #(.NREG(NREG), .CNT_W(CNT_W), .BR_TMO(BR_TMO)) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_data_stall (perf_data_stall),
        .perf_br_stall   (perf_br_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t expq[$];

    // Behavioural model state
    int          m_pend [NREG];
    bit          m_wait, m_redir, m_tmo, m_proto;
    logic [31:0] m_pc;
    int          m_wait_cnt;
    logic [31:0] m_pd, m_pb;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        m_wait = 0; m_redir = 0; m_tmo = 0; m_proto = 0;
        m_pc = '0; m_wait_cnt = 0; m_pd = '0; m_pb = '0;
    endfunction

    // Expected outputs for this cycle, then the state after the coming clock edge.
    function automatic void model_step(stim_t s);
        exp_t e;
        bit old_wait, old_redir, busy, issue, inc, dec;
        old_wait  = m_wait;
        old_redir = m_redir;
        busy      = old_wait || old_redir;
        e.hz   = s.dv && ((s.rs1 != 0 && m_pend[s.rs1] != 0) ||
                          (s.rs2 != 0 && m_pend[s.rs2] != 0) ||
                          (s.we && s.rd != 0 && m_pend[s.rd] == PEND_MAX));
        e.busy = busy;
        e.pc   = m_redir ? m_pc : 32'h0;
        e.err  = {m_tmo, m_proto};
        e.pd   = m_pd;
        e.pb   = m_pb;
        expq.push_back(e);

        m_pd  = m_pd + 32'(e.hz);
        m_pb  = m_pb + 32'(busy);
        issue = s.dv && !e.hz && !busy;
        inc   = issue && s.we && s.rd != 0;
        dec   = s.wv && s.wwe && s.wrd != 0;
        if (!(inc && dec && s.rd == s.wrd)) begin
            if (inc) begin
                if (m_pend[s.rd] == PEND_MAX) m_proto = 1; else m_pend[s.rd]++;
            end
            if (dec) begin
                if (m_pend[s.wrd] == 0) m_proto = 1; else m_pend[s.wrd]--;
            end
        end
        if (old_wait) begin
            m_wait_cnt++;
            if (m_wait_cnt == BR_TMO) m_tmo = 1;
            if (s.wbr) begin
                m_wait = 0; m_redir = 1; m_pc = s.tgt;
                if (s.tgt == 0) m_proto = 1;
            end
        end else if (old_redir) begin
            m_redir = 0;
        end else if (issue && s.br) begin
            m_wait = 1; m_wait_cnt = 0;
        end
        if (s.wbr && !old_wait) m_proto = 1;
        if (s.dv && s.br && busy) m_proto = 1;
    endfunction

    task automatic drive(stim_t s);
        bus.dec_valid     = s.dv;
        bus.dec_rs1       = s.rs1;
        bus.dec_rs2       = s.rs2;
        bus.dec_rd        = s.rd;
        bus.dec_rd_we     = s.we;
        bus.dec_is_branch = s.br;
        bus.wb_valid      = s.wv;
        bus.wb_rd         = s.wrd;
        bus.wb_rd_we      = s.wwe;
        bus.wb_br_valid   = s.wbr;
        bus.wb_br_target  = s.tgt;
    endtask

    task automatic cyc(stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        model_step(s);
    endtask

    task automatic idle(int n);
        stim_t s;
        s = '0;
        repeat (n) cyc(s);
    endtask

    task automatic issue_rd(logic [4:0] rd);
        stim_t s;
        s = '0; s.dv = 1; s.rd = rd; s.we = 1;
        cyc(s);
    endtask

    task automatic retire_rd(logic [4:0] rd);
        stim_t s;
        s = '0; s.wv = 1; s.wrd = rd; s.wwe = 1;
        cyc(s);
    endtask

    task automatic issue_branch();
        stim_t s;
        s = '0; s.dv = 1; s.br = 1;
        cyc(s);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        stim_t s;
        @(negedge clk);
        #2;
        rstd = 1'b0;
        model_reset();
        s = '0; s.dv = 1; s.rs1 = 5;
        drive(s);
        #1;
        check("rst_br_busy", 32'(bus.br_busy), 32'h0);
        check("rst_irreg_pc", bus.irreg_pc, 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_hazard_rs1_5", 32'(bus.is_data_hazard), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        s = '0;
        drive(s);
        rstd = 1'b1;
    endtask

    // Monitor: compare DUT outputs against queued expectations away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("is_data_hazard", 32'(bus.is_data_hazard), 32'(e.hz));
                check("br_busy", 32'(bus.br_busy), 32'(e.busy));
                check("irreg_pc", bus.irreg_pc, e.pc);
                check("err", 32'(bus.err), 32'(e.err));
`ifdef HAZARD_PERF_CNT_EN
                check("perf_data_stall", perf_data_stall, e.pd);
                check("perf_br_stall", perf_br_stall, e.pb);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        rstd = 1'b0;
        s = '0;
        drive(s);
        model_reset();
        #1;
        check("init_br_busy", 32'(bus.br_busy), 32'h0);
        check("init_irreg_pc", bus.irreg_pc, 32'h0);
        check("init_err", 32'(bus.err), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstd = 1'b1;

        // RAW on rd=5: stall until the cycle after its retire; rs1=0 never stalls
        issue_rd(5);
        s = '0; s.dv = 1; s.rs1 = 5;
        cyc(s); cyc(s);
        s.wv = 1; s.wrd = 5; s.wwe = 1;
        cyc(s);
        s = '0; s.dv = 1; s.rs1 = 5;
        cyc(s);
        s = '0; s.dv = 1; s.rs1 = 0; s.rs2 = 0;
        cyc(s);

        // Issue and retire of rd=7 in the same cycle leave its count unchanged
        issue_rd(7);
        s = '0; s.dv = 1; s.rd = 7; s.we = 1; s.rs1 = 1; s.wv = 1; s.wrd = 7; s.wwe = 1;
        cyc(s);
        s = '0; s.dv = 1; s.rs2 = 7;
        cyc(s); cyc(s);
        retire_rd(7);
        s = '0; s.dv = 1; s.rs2 = 7;
        cyc(s);

        // Branch resolved on the third wait cycle, redirect to 0x40 for one cycle
        issue_branch();
        idle(2);
        s = '0; s.wbr = 1; s.tgt = 32'h40;
        cyc(s);
        idle(3);

        // Counter saturation on rd=9, then an underflow retire sets err_proto
        repeat (3) issue_rd(9);
        issue_rd(9);
        issue_rd(9);
        repeat (3) retire_rd(9);
        s = '0; s.dv = 1; s.rs1 = 9;
        cyc(s);
        retire_rd(9);
        idle(2);

        // Reset while a branch is outstanding and rd=5 is pending
        issue_rd(5);
        issue_branch();
        idle(2);
        async_reset();
        s = '0; s.dv = 1; s.rs1 = 5;
        cyc(s);
        idle(1);

        // Randomised traffic over a small register window
        for (int i = 0; i < 800; i++) begin
            bit busy;
            busy = m_wait || m_redir;
            s = '0;
            s.dv  = ($urandom_range(0, 3) != 0);
            s.rs1 = 5'($urandom_range(0, 5));
            s.rs2 = 5'($urandom_range(0, 5));
            s.rd  = 5'($urandom_range(0, 5));
            s.we  = ($urandom_range(0, 3) != 0);
            s.br  = busy ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0);
            s.wv  = ($urandom_range(0, 1) == 1);
            s.wrd = 5'($urandom_range(0, 5));
            s.wwe = (m_pend[s.wrd] > 0) || ($urandom_range(0, 19) == 0);
            s.wbr = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            s.tgt = ($urandom_range(0, 29) == 0) ? 32'h0 : $urandom;
            cyc(s);
            if (i == 400) async_reset();
        end

        // Branch timeout: err_tmo after 64 wait cycles, FSM keeps waiting
        async_reset();
        issue_branch();
        idle(BR_TMO + 2);
        s = '0; s.wbr = 1; s.tgt = 32'h1234;
        cyc(s);
        idle(3);

        repeat (2) @(negedge clk);
        check("queue_drain", 32'(expq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
